// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: clips an axis-aligned rectangle to the framebuffer and
// writes one 16-bit colour per pixel through the memory bridge, row-major.
//
// state   | meaning
// IDLE    | waiting for start; inputs latched on start
// SETUP   | clip region, degenerate check, first row address
// WRITE   | write request held until acknowledge
// ADVANCE | one-cycle gap; step to next pixel or row
// FINISH  | done pulse, back to IDLE
module rect_fill_engine #(
    parameter int                FB_WIDTH  = 320,
    parameter int                FB_HEIGHT = 240,
    parameter int                ADDR_W    = 27,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [9:0]        x0,
    input  logic [8:0]        y0,
    input  logic [9:0]        w,
    input  logic [8:0]        h,
    input  logic [15:0]       color,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] bridge_memory_address,
    output logic [1:0]        bridge_memory_byte_enable,
    output logic              bridge_memory_read,
    output logic              bridge_memory_write,
    output logic [15:0]       bridge_memory_write_data,
    input  logic              bridge_memory_acknowledge,
    input  logic [15:0]       bridge_memory_read_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_WRITE,
        S_ADVANCE,
        S_FINISH
    } state_t;

    localparam logic [10:0]       X_LIM      = 11'(FB_WIDTH);
    localparam logic [9:0]        Y_LIM      = 10'(FB_HEIGHT);
    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(2 * FB_WIDTH);

    state_t            state_q, state_d;
    logic [9:0]        x0_q, x0_d;
    logic [8:0]        y0_q, y0_d;
    logic [9:0]        w_q, w_d;
    logic [8:0]        h_q, h_d;
    logic [15:0]       color_q, color_d;
    logic [9:0]        x_q, x_d;
    logic [8:0]        y_q, y_d;
    logic [10:0]       x_end_q, x_end_d;
    logic [9:0]        y_end_q, y_end_d;
    logic [ADDR_W-1:0] row_addr_q, row_addr_d;
    logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;

    logic [10:0]       x_sum;
    logic [9:0]        y_sum;
    logic [ADDR_W-1:0] row_base;
    logic              empty_rect;
    logic              unused_read_data;

    // Widened sums so x0+w and y0+h cannot wrap before clipping.
    assign x_sum      = {1'b0, x0_q} + {1'b0, w_q};
    assign y_sum      = {1'b0, y0_q} + {1'b0, h_q};
    assign row_base   = BASE_ADDR
                      + ((ADDR_W'(y0_q) * ADDR_W'(FB_WIDTH)) << 1)
                      + (ADDR_W'(x0_q) << 1);
    assign empty_rect = (w_q == '0) || (h_q == '0)
                      || ({1'b0, x0_q} >= X_LIM) || ({1'b0, y0_q} >= Y_LIM);

    assign unused_read_data = ^bridge_memory_read_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            x0_q       <= '0;
            y0_q       <= '0;
            w_q        <= '0;
            h_q        <= '0;
            color_q    <= '0;
            x_q        <= '0;
            y_q        <= '0;
            x_end_q    <= '0;
            y_end_q    <= '0;
            row_addr_q <= '0;
            pix_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            x0_q       <= x0_d;
            y0_q       <= y0_d;
            w_q        <= w_d;
            h_q        <= h_d;
            color_q    <= color_d;
            x_q        <= x_d;
            y_q        <= y_d;
            x_end_q    <= x_end_d;
            y_end_q    <= y_end_d;
            row_addr_q <= row_addr_d;
            pix_addr_q <= pix_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        x0_d       = x0_q;
        y0_d       = y0_q;
        w_d        = w_q;
        h_d        = h_q;
        color_d    = color_q;
        x_d        = x_q;
        y_d        = y_q;
        x_end_d    = x_end_q;
        y_end_d    = y_end_q;
        row_addr_d = row_addr_q;
        pix_addr_d = pix_addr_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x0_d    = x0;
                    y0_d    = y0;
                    w_d     = w;
                    h_d     = h;
                    color_d = color;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                x_end_d = (x_sum > X_LIM) ? X_LIM : x_sum;
                y_end_d = (y_sum > Y_LIM) ? Y_LIM : y_sum;
                if (empty_rect) begin
                    state_d = S_FINISH;
                end else begin
                    x_d        = x0_q;
                    y_d        = y0_q;
                    row_addr_d = row_base;
                    pix_addr_d = row_base;
                    state_d    = S_WRITE;
                end
            end
            S_WRITE: begin
                if (bridge_memory_acknowledge) begin
                    state_d = S_ADVANCE;
                end
            end
            S_ADVANCE: begin
                if (({1'b0, x_q} + 11'd1) < x_end_q) begin
                    x_d        = x_q + 10'd1;
                    pix_addr_d = pix_addr_q + ADDR_W'(2);
                    state_d    = S_WRITE;
                end else if (({1'b0, y_q} + 10'd1) < y_end_q) begin
                    x_d        = x0_q;
                    y_d        = y_q + 9'd1;
                    row_addr_d = row_addr_q + ROW_STRIDE;
                    pix_addr_d = row_addr_q + ROW_STRIDE;
                    state_d    = S_WRITE;
                end else begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy                      = (state_q == S_SETUP) || (state_q == S_WRITE)
                                     || (state_q == S_ADVANCE);
    assign done                      = (state_q == S_FINISH);
    assign bridge_memory_write       = (state_q == S_WRITE);
    assign bridge_memory_byte_enable = bridge_memory_write ? 2'b11 : 2'b00;
    assign bridge_memory_read        = 1'b0;
    assign bridge_memory_address     = pix_addr_q;
    assign bridge_memory_write_data  = color_q;

endmodule

// File: tb/tb_rect_fill_engine.sv
// Directed bench for rect_fill_engine: a table of fills run against a simple
// bridge responder, plus a reset-mid-fill sequence.
module tb_rect_fill_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  x0;
    logic [8:0]  y0;
    logic [9:0]  w;
    logic [8:0]  h;
    logic [15:0] color;
    logic        busy;
    logic        done;
    logic [26:0] addr;
    logic [1:0]  be;
    logic        rd;
    logic        wr;
    logic [15:0] wdata;
    logic        ack;

    rect_fill_engine dut (
        .clk                       (clk),
        .reset                     (reset),
        .start                     (start),
        .x0                        (x0),
        .y0                        (y0),
        .w                         (w),
        .h                         (h),
        .color                     (color),
        .busy                      (busy),
        .done                      (done),
        .bridge_memory_address     (addr),
        .bridge_memory_byte_enable (be),
        .bridge_memory_read        (rd),
        .bridge_memory_write       (wr),
        .bridge_memory_write_data  (wdata),
        .bridge_memory_acknowledge (ack),
        .bridge_memory_read_data   (16'h0000)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  x0;
        logic [8:0]  y0;
        logic [9:0]  w;
        logic [8:0]  h;
        logic [15:0] color;
        int          lat;
        bit          mid_start;
        int          exp_cnt;
        int          exp_first;
        int          exp_last;
        int          exp_dcyc;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    logic [26:0] wq[$];
    logic [26:0] mq[$];

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic build_model(input vec_t v);
        int xe, ye;
        mq.delete();
        xe = (int'(v.x0) + int'(v.w) > 320) ? 320 : int'(v.x0) + int'(v.w);
        ye = (int'(v.y0) + int'(v.h) > 240) ? 240 : int'(v.y0) + int'(v.h);
        for (int yy = int'(v.y0); yy < ye; yy++)
            for (int xx = int'(v.x0); xx < xe; xx++)
                mq.push_back(27'(2 * (yy * 320 + xx)));
    endtask

    task automatic run_fill(input vec_t v, input string tag);
        int c, cnt, gap, ndone, dcyc, post, unstable, gapbad, colbad, busybad;
        bit had_write, seen_done;
        logic [26:0] a_lat;
        logic [15:0] d_lat;
        c = 0; cnt = 0; gap = 0; ndone = 0; dcyc = -1; post = 0;
        unstable = 0; gapbad = 0; colbad = 0; busybad = 0;
        had_write = 0; seen_done = 0; a_lat = '0; d_lat = '0;
        wq.delete();
        build_model(v);
        @(negedge clk);
        x0 = v.x0; y0 = v.y0; w = v.w; h = v.h; color = v.color; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 1;
        while (c < 3000 && post < 3) begin
            ack = 1'b0;
            if (wr) begin
                if (cnt == 0) begin
                    wq.push_back(addr);
                    a_lat = addr;
                    d_lat = wdata;
                    if (had_write && gap != 1) gapbad++;
                    if (wdata !== v.color) colbad++;
                    if (be !== 2'b11) unstable++;
                end else if (addr !== a_lat || wdata !== d_lat || be !== 2'b11) begin
                    unstable++;
                end
                cnt++;
                if (cnt == v.lat + 1) ack = 1'b1;
                gap = 0;
                had_write = 1;
            end else begin
                cnt = 0;
                gap++;
                if (be !== 2'b00) unstable++;
            end
            if (rd !== 1'b0) unstable++;
            if (done) begin
                ndone++;
                if (!seen_done) dcyc = c;
                if (busy) busybad++;
                seen_done = 1;
            end else if (!seen_done && !busy) begin
                busybad++;
            end
            if (seen_done) post++;
            if (v.mid_start && c == 4) begin
                start = 1'b1; x0 = 10'd0; y0 = 9'd0; w = 10'd1; h = 9'd1; color = 16'h0EEE;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            c++;
        end
        ack = 1'b0;
        start = 1'b0;
        check({tag, "_done_seen"}, seen_done, 1);
        check({tag, "_nwrites"}, wq.size(), v.exp_cnt);
        if (v.exp_cnt > 0 && wq.size() > 0) begin
            check({tag, "_first_addr"}, wq[0], v.exp_first);
            check({tag, "_last_addr"}, wq[wq.size()-1], v.exp_last);
        end
        for (int i = 0; i < mq.size() && i < wq.size(); i++)
            check($sformatf("%s_addr%0d", tag, i), wq[i], mq[i]);
        check({tag, "_ndone"}, ndone, 1);
        check({tag, "_hold_stable"}, unstable, 0);
        check({tag, "_gap"}, gapbad, 0);
        check({tag, "_color"}, colbad, 0);
        check({tag, "_busy"}, busybad, 0);
        if (v.exp_dcyc != 0) check({tag, "_done_latency"}, dcyc, v.exp_dcyc);
    endtask

    vec_t tbl[8];
    vec_t rv;

    initial begin
        int k, nd;
        reset = 1'b1; start = 1'b0; ack = 1'b0;
        x0 = '0; y0 = '0; w = '0; h = '0; color = '0;

        tbl[0] = '{10'd10,  9'd5,   10'd3, 9'd2, 16'h0F00, 2,  1'b0, 6, 3220,   3864,   0};
        tbl[1] = '{10'd318, 9'd239, 10'd5, 9'd4, 16'h0ABC, 1,  1'b0, 2, 153596, 153598, 0};
        tbl[2] = '{10'd50,  9'd50,  10'd0, 9'd4, 16'h0FFF, 2,  1'b0, 0, 0,      0,      2};
        tbl[3] = '{10'd320, 9'd10,  10'd4, 9'd4, 16'h0F0F, 2,  1'b0, 0, 0,      0,      2};
        tbl[4] = '{10'd0,   9'd0,   10'd2, 9'd1, 16'h0123, 20, 1'b0, 2, 0,      2,      0};
        tbl[5] = '{10'd100, 9'd100, 10'd2, 9'd2, 16'h0321, 0,  1'b1, 4, 64200,  64842,  0};
        tbl[6] = '{10'd7,   9'd240, 10'd3, 9'd3, 16'h0555, 1,  1'b0, 0, 0,      0,      2};
        tbl[7] = '{10'd319, 9'd0,   10'd10, 9'd1, 16'h0777, 0, 1'b0, 1, 638,    638,    0};

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_write", wr, 0);
        check("rst_read", rd, 0);
        check("rst_addr", addr, 0);
        check("rst_be", be, 0);
        check("rst_wdata", wdata, 0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) run_fill(tbl[i], $sformatf("vec%0d", i));

        // Reset while a write is outstanding
        @(negedge clk);
        x0 = 10'd20; y0 = 9'd20; w = 10'd4; h = 9'd4; color = 16'h0F0F; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!wr && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("mid_rst_write_seen", wr, 1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_write", wr, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_be", be, 0);
        reset = 1'b0;
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            if (done || wr) nd++;
            @(negedge clk);
        end
        check("mid_rst_no_done", nd, 0);

        rv = '{10'd30, 9'd1, 10'd2, 9'd1, 16'h00F0, 2, 1'b0, 2, 700, 702, 0};
        run_fill(rv, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
